// File: rtl/keylock_controller_if.sv
// Keypad lock bus: keypad/control strobes toward the controller, lock status back.
interface keylock_controller_if #(
  parameter int unsigned FAIL_W = 2
);
  logic              key_valid;
  logic [3:0]        key;
  logic              relock;
  logic              prog;
  logic              locked;
  logic              lockout;
  logic              bad_attempt;
  logic              prog_done;
  logic [2:0]        digit_cnt;
  logic [FAIL_W-1:0] fail_cnt;

  modport master (
    output key_valid, key, relock, prog,
    input  locked, lockout, bad_attempt, prog_done, digit_cnt, fail_cnt
  );

  modport slave (
    input  key_valid, key, relock, prog,
    output locked, lockout, bad_attempt, prog_done, digit_cnt, fail_cnt
  );
endinterface

// File: rtl/keylock_controller.sv
// Keypad lock sequencer: collects digits, checks/programs the code,
// counts failed attempts and enforces a timed lockout.
module keylock_controller #(
  parameter int unsigned CODE_LEN       = 6,
  parameter int unsigned MAX_FAIL       = 3,
  parameter int unsigned LOCKOUT_CYCLES = 1000,
  parameter logic [31:0] DEFAULT_CODE   = 32'h0033_5256
) (
  input  logic               clk,
  input  logic               reset,
  keylock_controller_if.slave bus
);

  localparam int unsigned CODE_W = 4 * CODE_LEN;
  localparam int unsigned FAIL_W = $clog2(MAX_FAIL + 1);
  localparam int unsigned TMR_W  = $clog2(LOCKOUT_CYCLES + 1);

  localparam logic [2:0]        LAST_DIGIT = 3'(CODE_LEN - 1);
  localparam logic [FAIL_W-1:0] FAIL_LAST  = FAIL_W'(MAX_FAIL - 1);
  localparam logic [TMR_W-1:0]  TMR_LOAD   = TMR_W'(LOCKOUT_CYCLES);
  localparam logic [CODE_W-1:0] CODE_RST   = DEFAULT_CODE[CODE_W-1:0];
  localparam logic [3:0]        KEY_CLEAR  = 4'hC;

  typedef enum logic [1:0] {
    S_LOCKED   = 2'd0,
    S_UNLOCKED = 2'd1,
    S_PROGRAM  = 2'd2,
    S_LOCKOUT  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [CODE_W-1:0] buf_q, buf_d;
  logic [2:0]        digit_cnt_q, digit_cnt_d;
  logic [FAIL_W-1:0] fail_cnt_q, fail_cnt_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              locked_q, locked_d;
  logic              lockout_q, lockout_d;
  logic              bad_attempt_q, bad_attempt_d;
  logic              prog_done_q, prog_done_d;

  logic              is_digit;
  logic              is_clear;
  logic              last_digit;
  logic [CODE_W-1:0] shifted;

  assign is_digit   = bus.key_valid && (bus.key <= 4'd9);
  assign is_clear   = bus.key_valid && (bus.key == KEY_CLEAR);
  assign last_digit = (digit_cnt_q == LAST_DIGIT);
  assign shifted    = {buf_q[CODE_W-5:0], bus.key};

  // Next-state and output decode
  always_comb begin
    state_d       = state_q;
    code_d        = code_q;
    buf_d         = buf_q;
    digit_cnt_d   = digit_cnt_q;
    fail_cnt_d    = fail_cnt_q;
    timer_d       = timer_q;
    bad_attempt_d = 1'b0;
    prog_done_d   = 1'b0;

    case (state_q)
      S_LOCKED: begin
        if (is_digit) begin
          if (last_digit) begin
            buf_d       = '0;
            digit_cnt_d = 3'd0;
            if (shifted == code_q) begin
              state_d    = S_UNLOCKED;
              fail_cnt_d = '0;
            end else begin
              bad_attempt_d = 1'b1;
              fail_cnt_d    = fail_cnt_q + FAIL_W'(1);
              if (fail_cnt_q == FAIL_LAST) begin
                state_d = S_LOCKOUT;
                timer_d = TMR_LOAD;
              end
            end
          end else begin
            buf_d       = shifted;
            digit_cnt_d = digit_cnt_q + 3'd1;
          end
        end else if (is_clear) begin
          buf_d       = '0;
          digit_cnt_d = 3'd0;
        end
      end

      S_LOCKOUT: begin
        timer_d = timer_q - TMR_W'(1);
        if (timer_q == TMR_W'(1)) begin
          state_d    = S_LOCKED;
          fail_cnt_d = '0;
        end
      end

      S_UNLOCKED: begin
        if (bus.relock) begin
          state_d = S_LOCKED;
        end else if (bus.prog) begin
          state_d     = S_PROGRAM;
          buf_d       = '0;
          digit_cnt_d = 3'd0;
        end
      end

      S_PROGRAM: begin
        if (bus.relock) begin
          state_d     = S_LOCKED;
          buf_d       = '0;
          digit_cnt_d = 3'd0;
        end else if (is_clear) begin
          state_d     = S_UNLOCKED;
          buf_d       = '0;
          digit_cnt_d = 3'd0;
        end else if (is_digit) begin
          if (last_digit) begin
            code_d      = shifted;
            prog_done_d = 1'b1;
            state_d     = S_LOCKED;
            buf_d       = '0;
            digit_cnt_d = 3'd0;
          end else begin
            buf_d       = shifted;
            digit_cnt_d = digit_cnt_q + 3'd1;
          end
        end
      end

      default: state_d = S_LOCKED;
    endcase

    locked_d  = (state_d == S_LOCKED) || (state_d == S_LOCKOUT);
    lockout_d = (state_d == S_LOCKOUT);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_LOCKED;
      code_q        <= CODE_RST;
      buf_q         <= '0;
      digit_cnt_q   <= 3'd0;
      fail_cnt_q    <= '0;
      timer_q       <= '0;
      locked_q      <= 1'b1;
      lockout_q     <= 1'b0;
      bad_attempt_q <= 1'b0;
      prog_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      code_q        <= code_d;
      buf_q         <= buf_d;
      digit_cnt_q   <= digit_cnt_d;
      fail_cnt_q    <= fail_cnt_d;
      timer_q       <= timer_d;
      locked_q      <= locked_d;
      lockout_q     <= lockout_d;
      bad_attempt_q <= bad_attempt_d;
      prog_done_q   <= prog_done_d;
    end
  end

  assign bus.locked      = locked_q;
  assign bus.lockout     = lockout_q;
  assign bus.bad_attempt = bad_attempt_q;
  assign bus.prog_done   = prog_done_q;
  assign bus.digit_cnt   = digit_cnt_q;
  assign bus.fail_cnt    = fail_cnt_q;

endmodule
